// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions: response codes and a constant-evaluable log2 helper.
package axil_pkg;

  localparam logic [1:0] AXIL_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXIL_RESP_SLVERR = 2'b10;

  // Ceiling log2, usable in parameter/localparam expressions.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/axil_ram_mem.sv
// Simple dual-port RAM: one byte-enabled write port and one registered,
// read-first read port. Kept free of resets so it maps onto block RAM.
module axil_ram_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int ADDR_BITS  = 10
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_BITS-1:0]  wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [STRB_WIDTH-1:0] wr_strb,
  input  logic                  rd_en,
  input  logic [ADDR_BITS-1:0]  rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_BITS];

  // Byte-lane writes; only lanes with their strobe set are updated.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < STRB_WIDTH; i++) begin
        if (wr_strb[i]) begin
          mem[wr_addr][i*8 +: 8] <= wr_data[i*8 +: 8];
        end
      end
    end
  end

  // Registered read; a same-edge write is not visible yet, so reads return old data.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/axil_ram_responder.sv
// AXI4-Lite responder in front of a byte-writable RAM. Write address and
// write data each get a one-entry hold register; a write commits once both
// are held and the B channel can take a response. Reads are fully pipelined
// with one outstanding R beat. Addresses beyond the RAM answer SLVERR.
module axil_ram_responder
  import axil_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 16,
  parameter int STRB_WIDTH     = DATA_WIDTH / 8,
  parameter int MEM_WORDS_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic [2:0]            s_axil_awprot,
  input  logic                  s_axil_awvalid,
  output logic                  s_axil_awready,
  input  logic [DATA_WIDTH-1:0] s_axil_wdata,
  input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
  input  logic                  s_axil_wvalid,
  output logic                  s_axil_wready,
  output logic [1:0]            s_axil_bresp,
  output logic                  s_axil_bvalid,
  input  logic                  s_axil_bready,
  input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic [2:0]            s_axil_arprot,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  output logic [DATA_WIDTH-1:0] s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready
);

  localparam int LANE_BITS = clog2(STRB_WIDTH);
  localparam int INDEX_TOP = LANE_BITS + MEM_WORDS_LOG2;

  // An address is in range when every bit above the word-index field is zero.
  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
    return (addr >> INDEX_TOP) == '0;
  endfunction

  logic                  aw_held;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic                  w_held;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_WIDTH-1:0] w_strb_q;
  logic                  bvalid_q;
  logic [1:0]            bresp_q;
  logic                  rvalid_q;
  logic [1:0]            rresp_q;
  logic                  rdata_zero_q;
  logic [DATA_WIDTH-1:0] mem_rd_data;

  logic aw_hs;
  logic w_hs;
  logic ar_hs;
  logic commit;
  logic wr_ok;
  logic rd_ok;

  assign s_axil_awready = !aw_held;
  assign s_axil_wready  = !w_held;
  assign s_axil_arready = !rvalid_q || s_axil_rready;

  assign aw_hs  = s_axil_awvalid && s_axil_awready;
  assign w_hs   = s_axil_wvalid && s_axil_wready;
  assign ar_hs  = s_axil_arvalid && s_axil_arready;
  assign commit = aw_held && w_held && (!bvalid_q || s_axil_bready);
  assign wr_ok  = in_range(aw_addr_q);
  assign rd_ok  = in_range(s_axil_araddr);

  assign s_axil_bvalid = bvalid_q;
  assign s_axil_bresp  = bresp_q;
  assign s_axil_rvalid = rvalid_q;
  assign s_axil_rresp  = rresp_q;
  assign s_axil_rdata  = rdata_zero_q ? '0 : mem_rd_data;

  // Protection bits and the sub-word address bits carry no meaning here.
  logic unused_ok;
  assign unused_ok = &{1'b0, s_axil_awprot, s_axil_arprot, aw_addr_q, s_axil_araddr};

  // Write-address hold: fills on the AW handshake, empties when the write commits.
  always_ff @(posedge clk) begin
    if (rst) begin
      aw_held <= 1'b0;
    end else if (aw_hs) begin
      aw_held   <= 1'b1;
      aw_addr_q <= s_axil_awaddr;
    end else if (commit) begin
      aw_held <= 1'b0;
    end
  end

  // Write-data hold: fills on the W handshake, empties when the write commits.
  always_ff @(posedge clk) begin
    if (rst) begin
      w_held <= 1'b0;
    end else if (w_hs) begin
      w_held   <= 1'b1;
      w_data_q <= s_axil_wdata;
      w_strb_q <= s_axil_wstrb;
    end else if (commit) begin
      w_held <= 1'b0;
    end
  end

  // B channel: a commit loads a new response, which takes priority over retiring the old one.
  always_ff @(posedge clk) begin
    if (rst) begin
      bvalid_q <= 1'b0;
      bresp_q  <= AXIL_RESP_OKAY;
    end else if (commit) begin
      bvalid_q <= 1'b1;
      bresp_q  <= wr_ok ? AXIL_RESP_OKAY : AXIL_RESP_SLVERR;
    end else if (s_axil_bready) begin
      bvalid_q <= 1'b0;
    end
  end

  // R channel: an accepted AR loads a new beat; out-of-range reads force the data to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_q     <= 1'b0;
      rresp_q      <= AXIL_RESP_OKAY;
      rdata_zero_q <= 1'b1;
    end else if (ar_hs) begin
      rvalid_q     <= 1'b1;
      rresp_q      <= rd_ok ? AXIL_RESP_OKAY : AXIL_RESP_SLVERR;
      rdata_zero_q <= !rd_ok;
    end else if (s_axil_rready) begin
      rvalid_q <= 1'b0;
    end
  end

  axil_ram_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .STRB_WIDTH(STRB_WIDTH),
    .ADDR_BITS (MEM_WORDS_LOG2)
  ) u_mem (
    .clk    (clk),
    .wr_en  (commit && wr_ok && !rst),
    .wr_addr(aw_addr_q[LANE_BITS +: MEM_WORDS_LOG2]),
    .wr_data(w_data_q),
    .wr_strb(w_strb_q),
    .rd_en  (ar_hs && rd_ok && !rst),
    .rd_addr(s_axil_araddr[LANE_BITS +: MEM_WORDS_LOG2]),
    .rd_data(mem_rd_data)
  );

endmodule

// File: tb/tb_axil_ram_responder.sv
// Directed bench for axil_ram_responder: a per-cycle vector table for the
// basic write/read/strobe/out-of-range behaviour, then hand-written sequences
// for channel skew with B backpressure, read streaming, collision and reset.
module tb_axil_ram_responder;

  logic        clk;
  logic        rst;
  logic [15:0] s_axil_awaddr;
  logic [2:0]  s_axil_awprot;
  logic        s_axil_awvalid;
  logic        s_axil_awready;
  logic [31:0] s_axil_wdata;
  logic [3:0]  s_axil_wstrb;
  logic        s_axil_wvalid;
  logic        s_axil_wready;
  logic [1:0]  s_axil_bresp;
  logic        s_axil_bvalid;
  logic        s_axil_bready;
  logic [15:0] s_axil_araddr;
  logic [2:0]  s_axil_arprot;
  logic        s_axil_arvalid;
  logic        s_axil_arready;
  logic [31:0] s_axil_rdata;
  logic [1:0]  s_axil_rresp;
  logic        s_axil_rvalid;
  logic        s_axil_rready;

  int compared;
  int mismatched;

  typedef struct {
    logic        aw_valid;
    logic [15:0] aw_addr;
    logic        w_valid;
    logic [31:0] w_data;
    logic [3:0]  w_strb;
    logic        ar_valid;
    logic [15:0] ar_addr;
    logic        exp_awready;
    logic        exp_wready;
    logic        exp_bvalid;
    logic [1:0]  exp_bresp;
    logic        exp_arready;
    logic        exp_rvalid;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_rresp;
  } vec_t;

  vec_t vectors [14];

  axil_ram_responder #(
    .DATA_WIDTH    (32),
    .ADDR_WIDTH    (16),
    .STRB_WIDTH    (4),
    .MEM_WORDS_LOG2(10)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axil_awaddr (s_axil_awaddr),
    .s_axil_awprot (s_axil_awprot),
    .s_axil_awvalid(s_axil_awvalid),
    .s_axil_awready(s_axil_awready),
    .s_axil_wdata  (s_axil_wdata),
    .s_axil_wstrb  (s_axil_wstrb),
    .s_axil_wvalid (s_axil_wvalid),
    .s_axil_wready (s_axil_wready),
    .s_axil_bresp  (s_axil_bresp),
    .s_axil_bvalid (s_axil_bvalid),
    .s_axil_bready (s_axil_bready),
    .s_axil_araddr (s_axil_araddr),
    .s_axil_arprot (s_axil_arprot),
    .s_axil_arvalid(s_axil_arvalid),
    .s_axil_arready(s_axil_arready),
    .s_axil_rdata  (s_axil_rdata),
    .s_axil_rresp  (s_axil_rresp),
    .s_axil_rvalid (s_axil_rvalid),
    .s_axil_rready (s_axil_rready)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the stimulus itself gets stuck.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Move to the drive point just after the next rising edge.
  task automatic nextSlot();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    s_axil_awvalid = v.aw_valid;
    s_axil_awaddr  = v.aw_addr;
    s_axil_wvalid  = v.w_valid;
    s_axil_wdata   = v.w_data;
    s_axil_wstrb   = v.w_strb;
    s_axil_arvalid = v.ar_valid;
    s_axil_araddr  = v.ar_addr;
  endtask

  task automatic checkVector(input int idx, input vec_t v);
    checkOutput($sformatf("vec%0d_awready", idx), 32'(s_axil_awready), 32'(v.exp_awready));
    checkOutput($sformatf("vec%0d_wready", idx), 32'(s_axil_wready), 32'(v.exp_wready));
    checkOutput($sformatf("vec%0d_bvalid", idx), 32'(s_axil_bvalid), 32'(v.exp_bvalid));
    checkOutput($sformatf("vec%0d_arready", idx), 32'(s_axil_arready), 32'(v.exp_arready));
    checkOutput($sformatf("vec%0d_rvalid", idx), 32'(s_axil_rvalid), 32'(v.exp_rvalid));
    if (v.exp_bvalid) begin
      checkOutput($sformatf("vec%0d_bresp", idx), 32'(s_axil_bresp), 32'(v.exp_bresp));
    end
    if (v.exp_rvalid) begin
      checkOutput($sformatf("vec%0d_rdata", idx), s_axil_rdata, v.exp_rdata);
      checkOutput($sformatf("vec%0d_rresp", idx), 32'(s_axil_rresp), 32'(v.exp_rresp));
    end
  endtask

  task automatic doWrite(input logic [15:0] addr, input logic [31:0] data, input logic [3:0] strb,
                         input logic [1:0] exp_resp);
    nextSlot();
    s_axil_bready  = 1'b1;
    s_axil_awaddr  = addr;
    s_axil_awvalid = 1'b1;
    s_axil_wdata   = data;
    s_axil_wstrb   = strb;
    s_axil_wvalid  = 1'b1;
    #1;
    nextSlot();
    s_axil_awvalid = 1'b0;
    s_axil_wvalid  = 1'b0;
    #1;
    for (int n = 0; n < 10 && s_axil_bvalid !== 1'b1; n++) begin
      nextSlot();
      #1;
    end
    checkOutput($sformatf("wr_%0h_bvalid", addr), 32'(s_axil_bvalid), 32'd1);
    checkOutput($sformatf("wr_%0h_bresp", addr), 32'(s_axil_bresp), 32'(exp_resp));
  endtask

  task automatic doRead(input logic [15:0] addr, input logic [31:0] exp_data, input logic [1:0] exp_resp);
    nextSlot();
    s_axil_rready  = 1'b1;
    s_axil_araddr  = addr;
    s_axil_arvalid = 1'b1;
    #1;
    nextSlot();
    s_axil_arvalid = 1'b0;
    #1;
    for (int n = 0; n < 10 && s_axil_rvalid !== 1'b1; n++) begin
      nextSlot();
      #1;
    end
    checkOutput($sformatf("rd_%0h_rvalid", addr), 32'(s_axil_rvalid), 32'd1);
    checkOutput($sformatf("rd_%0h_rdata", addr), s_axil_rdata, exp_data);
    checkOutput($sformatf("rd_%0h_rresp", addr), 32'(s_axil_rresp), 32'(exp_resp));
  endtask

  // Main test sequence.
  initial begin
    compared       = 0;
    mismatched     = 0;
    rst            = 1'b1;
    s_axil_awaddr  = '0;
    s_axil_awprot  = '0;
    s_axil_awvalid = 1'b0;
    s_axil_wdata   = '0;
    s_axil_wstrb   = '0;
    s_axil_wvalid  = 1'b0;
    s_axil_bready  = 1'b1;
    s_axil_araddr  = '0;
    s_axil_arprot  = '0;
    s_axil_arvalid = 1'b0;
    s_axil_rready  = 1'b1;

    //           aw    awaddr    w     wdata         strb  ar    araddr    awr   wr    bv    bresp  arr   rv    rdata         rresp
    vectors[0]  = '{1'b1, 16'h0010, 1'b1, 32'hDEADBEEF, 4'hF, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 32'h00000000, 2'b00};
    vectors[1]  = '{1'b0, 16'h0000, 1'b0, 32'h00000000, 4'h0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 32'h00000000, 2'b00};
    vectors[2]  = '{1'b0, 16'h0000, 1'b0, 32'h00000000, 4'h0, 1'b1, 16'h0010, 1'b1, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 32'h00000000, 2'b00};
    vectors[3]  = '{1'b1, 16'h0020, 1'b1, 32'hFFFFFFFF, 4'hF, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 32'hDEADBEEF, 2'b00};
    vectors[4]  = '{1'b0, 16'h0000, 1'b0, 32'h00000000, 4'h0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 32'h00000000, 2'b00};
    vectors[5]  = '{1'b1, 16'h0020, 1'b1, 32'h11223344, 4'h5, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 32'h00000000, 2'b00};
    vectors[6]  = '{1'b0, 16'h0000, 1'b0, 32'h00000000, 4'h0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 32'h00000000, 2'b00};
    vectors[7]  = '{1'b0, 16'h0000, 1'b0, 32'h00000000, 4'h0, 1'b1, 16'h0020, 1'b1, 1'b1, 1'b1, 2'b00, 1'b1, 1'b0, 32'h00000000, 2'b00};
    vectors[8]  = '{1'b1, 16'h1000, 1'b1, 32'h12345678, 4'hF, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 32'hFF22FF44, 2'b00};
    vectors[9]  = '{1'b0, 16'h0000, 1'b0, 32'h00000000, 4'h0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 32'h00000000, 2'b00};
    vectors[10] = '{1'b0, 16'h0000, 1'b0, 32'h00000000, 4'h0, 1'b1, 16'h1000, 1'b1, 1'b1, 1'b1, 2'b10, 1'b1, 1'b0, 32'h00000000, 2'b00};
    vectors[11] = '{1'b0, 16'h0000, 1'b0, 32'h00000000, 4'h0, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 32'h00000000, 2'b10};
    vectors[12] = '{1'b0, 16'h0000, 1'b0, 32'h00000000, 4'h0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 32'h00001111, 2'b00};
    vectors[13] = '{1'b0, 16'h0000, 1'b0, 32'h00000000, 4'h0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 32'h00000000, 2'b00};

    // Reset state.
    repeat (3) @(posedge clk);
    #2;
    checkOutput("rst_bvalid", 32'(s_axil_bvalid), 32'd0);
    checkOutput("rst_rvalid", 32'(s_axil_rvalid), 32'd0);
    checkOutput("rst_bresp", 32'(s_axil_bresp), 32'd0);
    checkOutput("rst_rresp", 32'(s_axil_rresp), 32'd0);
    checkOutput("rst_rdata", s_axil_rdata, 32'd0);
    checkOutput("rst_awready", 32'(s_axil_awready), 32'd1);
    checkOutput("rst_wready", 32'(s_axil_wready), 32'd1);
    checkOutput("rst_arready", 32'(s_axil_arready), 32'd1);
    rst = 1'b0;

    // Known contents for later reads.
    doWrite(16'h0000, 32'h00001111, 4'hF, 2'b00);
    doWrite(16'h0004, 32'h22220004, 4'hF, 2'b00);
    doWrite(16'h0008, 32'h33330008, 4'hF, 2'b00);
    doWrite(16'h0030, 32'hA5A5A5A5, 4'hF, 2'b00);
    doWrite(16'h0050, 32'h12345678, 4'hF, 2'b00);

    // Table: basic write/read, byte strobes, out-of-range write and read.
    for (int i = 0; i < 14; i++) begin
      nextSlot();
      applyStimulus(vectors[i]);
      #1;
      checkVector(i, vectors[i]);
    end

    // Channel skew: W three cycles ahead of AW, then a second write stalled behind B.
    nextSlot();
    s_axil_bready = 1'b0;
    s_axil_wdata  = 32'hCAFE0001;
    s_axil_wstrb  = 4'hF;
    s_axil_wvalid = 1'b1;
    #1;
    checkOutput("skew_wready_first", 32'(s_axil_wready), 32'd1);
    nextSlot();
    s_axil_wvalid = 1'b0;
    #1;
    checkOutput("skew_wready_held", 32'(s_axil_wready), 32'd0);
    checkOutput("skew_awready_idle", 32'(s_axil_awready), 32'd1);
    checkOutput("skew_bvalid_early", 32'(s_axil_bvalid), 32'd0);
    nextSlot();
    #1;
    checkOutput("skew_wready_held2", 32'(s_axil_wready), 32'd0);
    nextSlot();
    s_axil_awaddr  = 16'h0040;
    s_axil_awvalid = 1'b1;
    #1;
    checkOutput("skew_awready_first", 32'(s_axil_awready), 32'd1);
    nextSlot();
    s_axil_awvalid = 1'b0;
    #1;
    checkOutput("skew_awready_held", 32'(s_axil_awready), 32'd0);
    checkOutput("skew_bvalid_latency", 32'(s_axil_bvalid), 32'd0);
    nextSlot();
    s_axil_awaddr  = 16'h1044;
    s_axil_awvalid = 1'b1;
    s_axil_wdata   = 32'hCAFE0002;
    s_axil_wvalid  = 1'b1;
    #1;
    checkOutput("skew_b1_bvalid", 32'(s_axil_bvalid), 32'd1);
    checkOutput("skew_b1_bresp", 32'(s_axil_bresp), 32'd0);
    checkOutput("skew_second_awready", 32'(s_axil_awready), 32'd1);
    checkOutput("skew_second_wready", 32'(s_axil_wready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      nextSlot();
      s_axil_awvalid = 1'b0;
      s_axil_wvalid  = 1'b0;
      #1;
      checkOutput($sformatf("stall%0d_bvalid", i), 32'(s_axil_bvalid), 32'd1);
      checkOutput($sformatf("stall%0d_bresp", i), 32'(s_axil_bresp), 32'd0);
      checkOutput($sformatf("stall%0d_awready", i), 32'(s_axil_awready), 32'd0);
      checkOutput($sformatf("stall%0d_wready", i), 32'(s_axil_wready), 32'd0);
    end
    nextSlot();
    s_axil_bready = 1'b1;
    #1;
    checkOutput("release_bvalid", 32'(s_axil_bvalid), 32'd1);
    checkOutput("release_bresp", 32'(s_axil_bresp), 32'd0);
    checkOutput("release_awready", 32'(s_axil_awready), 32'd0);
    nextSlot();
    #1;
    checkOutput("b2_bvalid", 32'(s_axil_bvalid), 32'd1);
    checkOutput("b2_bresp", 32'(s_axil_bresp), 32'd2);
    checkOutput("b2_awready", 32'(s_axil_awready), 32'd1);
    checkOutput("b2_wready", 32'(s_axil_wready), 32'd1);
    nextSlot();
    #1;
    checkOutput("b2_retired", 32'(s_axil_bvalid), 32'd0);
    doRead(16'h0040, 32'hCAFE0001, 2'b00);

    // Read streaming with rready 1,0,1.
    nextSlot();
    s_axil_araddr  = 16'h0000;
    s_axil_arvalid = 1'b1;
    s_axil_rready  = 1'b1;
    #1;
    checkOutput("strm_arready0", 32'(s_axil_arready), 32'd1);
    nextSlot();
    s_axil_araddr = 16'h0004;
    s_axil_rready = 1'b0;
    #1;
    checkOutput("strm_rvalid0", 32'(s_axil_rvalid), 32'd1);
    checkOutput("strm_rdata0", s_axil_rdata, 32'h00001111);
    checkOutput("strm_arready_stall", 32'(s_axil_arready), 32'd0);
    nextSlot();
    s_axil_rready = 1'b1;
    #1;
    checkOutput("strm_rdata0_stable", s_axil_rdata, 32'h00001111);
    checkOutput("strm_arready1", 32'(s_axil_arready), 32'd1);
    nextSlot();
    s_axil_araddr = 16'h0008;
    #1;
    checkOutput("strm_rdata1", s_axil_rdata, 32'h22220004);
    checkOutput("strm_rvalid1", 32'(s_axil_rvalid), 32'd1);
    nextSlot();
    s_axil_arvalid = 1'b0;
    #1;
    checkOutput("strm_rdata2", s_axil_rdata, 32'h33330008);
    checkOutput("strm_rvalid2", 32'(s_axil_rvalid), 32'd1);
    nextSlot();
    #1;
    checkOutput("strm_rvalid_done", 32'(s_axil_rvalid), 32'd0);

    // Collision: read and commit to the same word on the same edge.
    nextSlot();
    s_axil_awaddr  = 16'h0030;
    s_axil_awvalid = 1'b1;
    s_axil_wdata   = 32'h5A5A5A5A;
    s_axil_wstrb   = 4'hF;
    s_axil_wvalid  = 1'b1;
    #1;
    nextSlot();
    s_axil_awvalid = 1'b0;
    s_axil_wvalid  = 1'b0;
    s_axil_araddr  = 16'h0030;
    s_axil_arvalid = 1'b1;
    #1;
    checkOutput("coll_awready", 32'(s_axil_awready), 32'd0);
    checkOutput("coll_arready", 32'(s_axil_arready), 32'd1);
    nextSlot();
    s_axil_arvalid = 1'b0;
    #1;
    checkOutput("coll_bvalid", 32'(s_axil_bvalid), 32'd1);
    checkOutput("coll_rvalid", 32'(s_axil_rvalid), 32'd1);
    checkOutput("coll_rdata_old", s_axil_rdata, 32'hA5A5A5A5);
    doRead(16'h0030, 32'h5A5A5A5A, 2'b00);

    // Reset with only AW held: the partial write must vanish.
    nextSlot();
    s_axil_awaddr  = 16'h0050;
    s_axil_awvalid = 1'b1;
    #1;
    nextSlot();
    s_axil_awvalid = 1'b0;
    rst            = 1'b1;
    #1;
    checkOutput("rstmid_awready_held", 32'(s_axil_awready), 32'd0);
    nextSlot();
    rst = 1'b0;
    #1;
    checkOutput("rstmid_awready", 32'(s_axil_awready), 32'd1);
    checkOutput("rstmid_wready", 32'(s_axil_wready), 32'd1);
    checkOutput("rstmid_bvalid", 32'(s_axil_bvalid), 32'd0);
    nextSlot();
    s_axil_wdata  = 32'h87654321;
    s_axil_wstrb  = 4'hF;
    s_axil_wvalid = 1'b1;
    #1;
    nextSlot();
    s_axil_wvalid = 1'b0;
    #1;
    checkOutput("rstmid_wready_held", 32'(s_axil_wready), 32'd0);
    checkOutput("rstmid_no_commit", 32'(s_axil_bvalid), 32'd0);
    nextSlot();
    #1;
    checkOutput("rstmid_no_commit2", 32'(s_axil_bvalid), 32'd0);
    doRead(16'h0050, 32'h12345678, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
